stack_ctrl: RTL and testbench
=============================

STACK_CTRL -- requirements
Module: stack_ctrl

Interface
REQ-001 Parameter DW, default 8, data width of each stack entry.
REQ-002 Parameter DEPTH, default 16, number of entries; legal values are powers of two from 4 to 256.
REQ-003 Derived CW = $clog2(DEPTH+1), width of the occupancy count.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 clr  input  1  synchronous empty request; also clears sticky error.
REQ-007 op  input  3  operation code: NOP=0, PUSH=1, POP1=2, POP2=3, BINOP=4, REPL=5, DUP=6, SWAP=7.
REQ-008 din  input  DW  write data for PUSH, BINOP and REPL.
REQ-009 tos  output  DW  top-of-stack entry; 0 when count==0.
REQ-010 nos  output  DW  next-of-stack entry; 0 when count<2.
REQ-011 count  output  CW  current number of valid entries, 0..DEPTH.
REQ-012 empty  output  1  count==0.
REQ-013 full  output  1  count==DEPTH.
REQ-014 ovf  output  1  one-cycle pulse; the previous op was rejected for lack of space.
REQ-015 unf  output  1  one-cycle pulse; the previous op was rejected for lack of entries.
REQ-016 err  output  1  sticky OR of all ovf/unf events since the last reset or clr.

Function
REQ-017 Entry mem[count-1] SHALL be TOS; entry mem[count-2] SHALL be NOS.
REQ-018 tos, nos, empty and full SHALL be combinational from the registered count and storage, so they reflect an op in the cycle after the op's edge.
REQ-019 NOP SHALL leave all state unchanged.
REQ-020 PUSH SHALL require count<DEPTH, then write mem[count]<=din and set count<=count+1.
REQ-021 POP1 SHALL require count>=1, then set count<=count-1.
REQ-022 POP2 SHALL require count>=2, then set count<=count-2.
REQ-023 BINOP SHALL require count>=2, then write mem[count-2]<=din and set count<=count-1; the external ALU result is supplied on din in the same cycle.
REQ-024 REPL SHALL require count>=1, then write mem[count-1]<=din with count unchanged.
REQ-025 DUP SHALL require 1<=count<DEPTH, then write mem[count]<=mem[count-1] and set count<=count+1.
REQ-026 SWAP SHALL require count>=2, then exchange mem[count-1] and mem[count-2] in one edge, with count unchanged.
REQ-027 On an insufficient-entry condition, the op SHALL leave storage and count unchanged and assert unf on the next cycle for exactly one cycle.
REQ-028 On an insufficient-space condition (PUSH when full, DUP when full), the op SHALL leave storage and count unchanged and assert ovf on the next cycle for exactly one cycle.
REQ-029 DUP with count==0 SHALL signal unf only; ovf and unf SHALL never assert together.
REQ-030 err SHALL set on any ovf/unf event and hold until reset or clr.
REQ-031 clr SHALL take priority over op: count<=0, err<=0, ovf<=0, unf<=0, and the op in that cycle is ignored.
REQ-032 Storage outside 0..count-1 is don't-care; no output SHALL depend on it.
REQ-033 count arithmetic SHALL never wrap; illegal ops are the only way to reach the limits, and they are rejected.

Reset
REQ-034 While reset==0, the block SHALL asynchronously force count=0, ovf=0, unf=0 and err=0; tos=nos=0, empty=1 and full=0 follow from this.
REQ-035 Storage SHALL NOT be reset.
REQ-036 Reset asserted mid-sequence SHALL abandon any op in flight with no partial write visible.
REQ-037 The first op SHALL be accepted on the first rising edge after reset deasserts.

Verification (DW=8, DEPTH=4)
REQ-038 Reset, then PUSH 0x11, 0x22, 0x33 -> count=3, tos=0x33, nos=0x22, empty=0, full=0.
REQ-039 From that state, PUSH 0x44 then PUSH 0x55 -> count=4, full=1; the second push sets ovf=1 for one cycle and err=1; tos stays 0x44.
REQ-040 From stack [0x11,0x22,0x33,0x44], SWAP -> tos=0x33, nos=0x44; then BINOP with din=0x77 -> count=3, tos=0x77, nos=0x22.
REQ-041 From a stack holding one entry 0x5A, DUP -> count=2, tos=nos=0x5A; then POP2 -> empty=1; then POP1 -> unf pulse, count stays 0.
REQ-042 With err=1 and count=3, assert clr together with op=PUSH -> count=0, err=0, and no write occurs.
REQ-043 Assert reset low asynchronously between edges with count=2 -> count=0 and tos=0 immediately, before the next clk edge.

Source files
------------

// File: rtl/stack_ctrl.sv
// LIFO stack controller: operand-stack storage with push/pop/dup/swap/binop/repl ops,
// occupancy tracking, and one-cycle overflow/underflow pulses plus a sticky error flag.
module stack_ctrl #(
    parameter int DW    = 8,
    parameter int DEPTH = 16,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic [2:0]    op,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] tos,
    output logic [DW-1:0] nos,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full,
    output logic          ovf,
    output logic          unf,
    output logic          err
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_PUSH  = 3'd1,
        OP_POP1  = 3'd2,
        OP_POP2  = 3'd3,
        OP_BINOP = 3'd4,
        OP_REPL  = 3'd5,
        OP_DUP   = 3'd6,
        OP_SWAP  = 3'd7
    } op_e;

    logic [DW-1:0] r_mem [DEPTH];
    logic [CW-1:0] r_count;
    logic          r_ovf;
    logic          r_unf;
    logic          r_err;

    op_e           w_op;
    logic          w_has1;
    logic          w_has2;
    logic          w_full;
    logic [AW-1:0] w_push_idx;
    logic [AW-1:0] w_top_idx;
    logic [AW-1:0] w_nos_idx;
    logic [DW-1:0] w_top_data;
    logic [DW-1:0] w_nos_data;

    logic [CW-1:0] w_next_count;
    logic          w_ovf;
    logic          w_unf;
    logic          w_wa_en;
    logic [AW-1:0] w_wa_idx;
    logic [DW-1:0] w_wa_data;
    logic          w_wb_en;
    logic [AW-1:0] w_wb_idx;
    logic [DW-1:0] w_wb_data;

    assign w_op   = op_e'(op);
    assign w_has1 = (r_count != '0);
    assign w_has2 = (r_count >= CW'(2));
    assign w_full = (r_count == CW'(DEPTH));

    // Low AW bits wrap to DEPTH-1 when count==DEPTH, which is exactly the TOS slot.
    assign w_push_idx = r_count[AW-1:0];
    assign w_top_idx  = r_count[AW-1:0] - AW'(1);
    assign w_nos_idx  = r_count[AW-1:0] - AW'(2);
    assign w_top_data = r_mem[w_top_idx];
    assign w_nos_data = r_mem[w_nos_idx];

    always_comb begin
        w_next_count = r_count;
        w_ovf        = 1'b0;
        w_unf        = 1'b0;
        w_wa_en      = 1'b0;
        w_wa_idx     = w_push_idx;
        w_wa_data    = din;
        w_wb_en      = 1'b0;
        w_wb_idx     = w_nos_idx;
        w_wb_data    = w_top_data;
        case (w_op)
            OP_PUSH: begin
                if (w_full) begin
                    w_ovf = 1'b1;
                end else begin
                    w_wa_en      = 1'b1;
                    w_next_count = r_count + CW'(1);
                end
            end
            OP_POP1: begin
                if (!w_has1) w_unf = 1'b1;
                else         w_next_count = r_count - CW'(1);
            end
            OP_POP2: begin
                if (!w_has2) w_unf = 1'b1;
                else         w_next_count = r_count - CW'(2);
            end
            OP_BINOP: begin
                if (!w_has2) begin
                    w_unf = 1'b1;
                end else begin
                    w_wa_en      = 1'b1;
                    w_wa_idx     = w_nos_idx;
                    w_next_count = r_count - CW'(1);
                end
            end
            OP_REPL: begin
                if (!w_has1) begin
                    w_unf = 1'b1;
                end else begin
                    w_wa_en  = 1'b1;
                    w_wa_idx = w_top_idx;
                end
            end
            OP_DUP: begin
                // Empty takes precedence so ovf and unf are never raised together.
                if (!w_has1) begin
                    w_unf = 1'b1;
                end else if (w_full) begin
                    w_ovf = 1'b1;
                end else begin
                    w_wa_en      = 1'b1;
                    w_wa_data    = w_top_data;
                    w_next_count = r_count + CW'(1);
                end
            end
            OP_SWAP: begin
                if (!w_has2) begin
                    w_unf = 1'b1;
                end else begin
                    w_wa_en   = 1'b1;
                    w_wa_idx  = w_top_idx;
                    w_wa_data = w_nos_data;
                    w_wb_en   = 1'b1;
                    w_wb_idx  = w_nos_idx;
                    w_wb_data = w_top_data;
                end
            end
            default: ;
        endcase
    end

    // Storage is not reset; slots above count are never observed.
    always_ff @(posedge clk) begin
        if (!clr) begin
            if (w_wa_en) r_mem[w_wa_idx] <= w_wa_data;
            if (w_wb_en) r_mem[w_wb_idx] <= w_wb_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
            r_err   <= 1'b0;
        end else if (clr) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_count <= w_next_count;
            r_ovf   <= w_ovf;
            r_unf   <= w_unf;
            r_err   <= r_err | w_ovf | w_unf;
        end
    end

    assign tos   = w_has1 ? w_top_data : '0;
    assign nos   = w_has2 ? w_nos_data : '0;
    assign count = r_count;
    assign empty = !w_has1;
    assign full  = w_full;
    assign ovf   = r_ovf;
    assign unf   = r_unf;
    assign err   = r_err;

endmodule

// File: tb/tb_stack_ctrl.sv
// Randomized bench for stack_ctrl with a queue-based reference model checked every cycle,
// plus directed sequences with literal expectations.
module tb_stack_ctrl;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk;
    logic          reset;
    logic          clr;
    logic [2:0]    op;
    logic [DW-1:0] din;
    logic [DW-1:0] tos;
    logic [DW-1:0] nos;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;
    logic          ovf;
    logic          unf;
    logic          err;

    stack_ctrl #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .op    (op),
        .din   (din),
        .tos   (tos),
        .nos   (nos),
        .count (count),
        .empty (empty),
        .full  (full),
        .ovf   (ovf),
        .unf   (unf),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    logic [DW-1:0] q[$];
    bit m_ovf, m_unf, m_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_err = 1'b0;
    endtask

    task automatic model_apply(input bit c, input logic [2:0] o, input logic [DW-1:0] d);
        int n;
        logic [DW-1:0] t;
        if (c) begin
            model_clear();
            return;
        end
        n = q.size();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        case (o)
            3'd1: if (n == DEPTH) m_ovf = 1'b1; else q.push_back(d);
            3'd2: if (n < 1) m_unf = 1'b1; else void'(q.pop_back());
            3'd3: if (n < 2) m_unf = 1'b1; else begin void'(q.pop_back()); void'(q.pop_back()); end
            3'd4: if (n < 2) m_unf = 1'b1; else begin void'(q.pop_back()); q[n-2] = d; end
            3'd5: if (n < 1) m_unf = 1'b1; else q[n-1] = d;
            3'd6: if (n < 1) m_unf = 1'b1; else if (n == DEPTH) m_ovf = 1'b1; else q.push_back(q[n-1]);
            3'd7: if (n < 2) m_unf = 1'b1; else begin t = q[n-1]; q[n-1] = q[n-2]; q[n-2] = t; end
            default: ;
        endcase
        m_err = m_err | m_ovf | m_unf;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            int n;
            n = q.size();
            check("tos",   32'(tos),   (n >= 1) ? 32'(q[n-1]) : 32'd0);
            check("nos",   32'(nos),   (n >= 2) ? 32'(q[n-2]) : 32'd0);
            check("count", 32'(count), 32'(n));
            check("empty", 32'(empty), 32'(n == 0));
            check("full",  32'(full),  32'(n == DEPTH));
            check("ovf",   32'(ovf),   32'(m_ovf));
            check("unf",   32'(unf),   32'(m_unf));
            check("err",   32'(err),   32'(m_err));
        end
    end

    // Called at a negedge; applies one op across the next posedge and returns at the following negedge.
    task automatic step(input bit c, input logic [2:0] o, input logic [DW-1:0] d);
        clr = c;
        op  = o;
        din = d;
        @(posedge clk);
        model_apply(c, o, d);
        @(negedge clk);
        clr = 1'b0;
        op  = 3'd0;
    endtask

    task automatic async_reset();
        #2 reset = 1'b0;
        #1;
        check("rst_count", 32'(count), 32'd0);
        check("rst_tos",   32'(tos),   32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        model_clear();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        logic [2:0] o;
        int sel;
        reset = 1'b0;
        clr   = 1'b0;
        op    = 3'd0;
        din   = '0;
        model_clear();
        repeat (2) @(negedge clk);
        check("init_count", 32'(count), 32'd0);
        check("init_empty", 32'(empty), 32'd1);
        check("init_full",  32'(full),  32'd0);
        check("init_err",   32'(err),   32'd0);
        reset  = 1'b1;
        chk_en = 1'b1;

        step(0, 3'd1, 8'h11);
        step(0, 3'd1, 8'h22);
        step(0, 3'd1, 8'h33);
        check("p3_count", 32'(count), 32'd3);
        check("p3_tos",   32'(tos),   32'h33);
        check("p3_nos",   32'(nos),   32'h22);
        check("p3_empty", 32'(empty), 32'd0);
        step(0, 3'd1, 8'h44);
        step(0, 3'd1, 8'h55);
        check("ovf_count", 32'(count), 32'd4);
        check("ovf_full",  32'(full),  32'd1);
        check("ovf_pulse", 32'(ovf),   32'd1);
        check("ovf_err",   32'(err),   32'd1);
        check("ovf_tos",   32'(tos),   32'h44);
        step(0, 3'd0, 8'h00);
        check("ovf_drop",  32'(ovf),   32'd0);
        check("err_hold",  32'(err),   32'd1);

        step(0, 3'd7, 8'h00);
        check("swap_tos", 32'(tos), 32'h33);
        check("swap_nos", 32'(nos), 32'h44);
        step(0, 3'd4, 8'h77);
        check("bin_count", 32'(count), 32'd3);
        check("bin_tos",   32'(tos),   32'h77);
        check("bin_nos",   32'(nos),   32'h22);

        step(1, 3'd1, 8'h99);
        check("clr_count", 32'(count), 32'd0);
        check("clr_err",   32'(err),   32'd0);
        check("clr_tos",   32'(tos),   32'd0);

        step(0, 3'd1, 8'h5A);
        step(0, 3'd6, 8'h00);
        check("dup_count", 32'(count), 32'd2);
        check("dup_tos",   32'(tos),   32'h5A);
        check("dup_nos",   32'(nos),   32'h5A);
        step(0, 3'd3, 8'h00);
        check("pop2_empty", 32'(empty), 32'd1);
        step(0, 3'd2, 8'h00);
        check("unf_pulse", 32'(unf),   32'd1);
        check("unf_ovf",   32'(ovf),   32'd0);
        check("unf_count", 32'(count), 32'd0);
        step(0, 3'd6, 8'h00);
        check("dup0_unf", 32'(unf), 32'd1);
        check("dup0_ovf", 32'(ovf), 32'd0);

        step(0, 3'd1, 8'hA1);
        step(0, 3'd1, 8'hB2);
        check("pre_rst_count", 32'(count), 32'd2);
        async_reset();
        step(0, 3'd1, 8'hC3);
        check("first_op_tos", 32'(tos), 32'hC3);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                async_reset();
            end else begin
                sel = $urandom_range(0, 11);
                o = (sel < 4) ? 3'd1 : 3'(sel - 4);
                step($urandom_range(0, 40) == 0, o, 8'($urandom));
            end
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
